// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART <-> ALU sequencing controller:
// state encoding and default parameter values.
package uart_ctrl_pkg;

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  localparam int DEFAULT_NBITS    = 8;
  localparam int DEFAULT_NBITS_OP = 6;
  localparam int DEFAULT_TIMEOUT  = 1_000_000;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter. Counts while enabled, and pulses 'expired' for
// the cycle in which the count reaches TIMEOUT-1. TIMEOUT=0 disables expiry.
module frame_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // The controller leaves the timed states on expiry, so this stays one cycle wide.
  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects an {A, B, opcode} frame from the UART receiver, drives the ALU,
// then hands the ALU result to the UART transmitter and waits for it to finish.
module uart_alu_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int NBITS    = DEFAULT_NBITS,
  parameter int NBITS_OP = DEFAULT_NBITS_OP,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                CLK_100MHZ,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [NBITS-1:0]    rx_data,
  input  logic                tx_done_tick,
  input  logic [NBITS-1:0]    alu_result,
  output logic [NBITS-1:0]    alu_a,
  output logic [NBITS-1:0]    alu_b,
  output logic [NBITS_OP-1:0] alu_op,
  output logic                tx_start,
  output logic [NBITS-1:0]    tx_data,
  output logic                done,
  output logic                frame_err,
  output logic                overrun
);

  logic [2:0] state;
  logic       timer_active;
  logic       timer_clear;
  logic       timer_expired;
  logic       busy;

  assign timer_active = (state == WAIT_B) || (state == WAIT_OP);
  assign timer_clear  = rx_done_tick || !timer_active;
  assign busy         = (state == COMPUTE) || (state == SEND) || (state == WAIT_TX);

  generate
    if (NBITS > NBITS_OP) begin : g_op_unused
      logic unused_rx_bits;
      assign unused_rx_bits = ^rx_data[NBITS-1:NBITS_OP];
    end
  endgenerate

  frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_frame_timer (
    .clk    (CLK_100MHZ),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_active),
    .expired(timer_expired)
  );

  // Frame sequencing. A byte arriving in the expiry cycle takes priority over
  // the timeout; the result is captured on the COMPUTE->SEND edge so tx_data
  // is already valid while tx_start is high.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      state     <= WAIT_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_A: begin
          if (rx_done_tick) begin
            alu_a <= rx_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done_tick) begin
            alu_b <= rx_data;
            state <= WAIT_OP;
          end else if (timer_expired) begin
            frame_err <= 1'b1;
            state     <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (rx_done_tick) begin
            alu_op <= rx_data[NBITS_OP-1:0];
            state  <= COMPUTE;
          end else if (timer_expired) begin
            frame_err <= 1'b1;
            state     <= WAIT_A;
          end
        end
        COMPUTE: begin
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) begin
            done  <= 1'b1;
            state <= WAIT_A;
          end
        end
        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

  // Sticky record of any byte dropped because a frame was still in flight.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (rx_done_tick && busy) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: vector table, randomized frames
// against a reference ALU model, and hand-written timeout/overrun/reset cases.
module tb_uart_alu_ctrl;

  localparam int NB = 8;
  localparam int NO = 6;
  localparam int TO = 50;

  logic          clk;
  logic          reset;
  logic          rx_done_tick;
  logic [NB-1:0] rx_data;
  logic          tx_done_tick;
  logic [NB-1:0] alu_result;
  logic [NB-1:0] alu_a;
  logic [NB-1:0] alu_b;
  logic [NO-1:0] alu_op;
  logic          tx_start;
  logic [NB-1:0] tx_data;
  logic          done;
  logic          frame_err;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  uart_alu_ctrl #(
    .NBITS   (NB),
    .NBITS_OP(NO),
    .TIMEOUT (TO)
  ) dut (
    .CLK_100MHZ  (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .tx_done_tick(tx_done_tick),
    .alu_result  (alu_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .done        (done),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, MIPS-style function codes.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   alu_model = a + b;
      6'h22:   alu_model = a - b;
      6'h24:   alu_model = a & b;
      6'h25:   alu_model = a | b;
      6'h26:   alu_model = a ^ b;
      6'h27:   alu_model = ~(a | b);
      6'h02:   alu_model = a >> b;
      6'h03:   alu_model = 8'(sa >>> b);
      default: alu_model = 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_byte;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " alu_a"}, alu_a, 0);
    checkOutput({tag, " alu_b"}, alu_b, 0);
    checkOutput({tag, " alu_op"}, alu_op, 0);
    checkOutput({tag, " tx_start"}, tx_start, 0);
    checkOutput({tag, " tx_data"}, tx_data, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " frame_err"}, frame_err, 0);
    checkOutput({tag, " overrun"}, overrun, 0);
  endtask

  // Called right after the opcode byte edge; leaves the DUT waiting for tx_done.
  task automatic complete_frame(input logic [7:0] ea, input logic [7:0] eb,
                                input logic [5:0] eop, input logic [7:0] etx,
                                input string tag);
    checkOutput({tag, " alu_a"}, alu_a, ea);
    checkOutput({tag, " alu_b"}, alu_b, eb);
    checkOutput({tag, " alu_op"}, alu_op, eop);
    checkOutput({tag, " tx_start early"}, tx_start, 0);
    idle(1);
    checkOutput({tag, " tx_start"}, tx_start, 1);
    checkOutput({tag, " tx_data"}, tx_data, etx);
    idle(1);
    checkOutput({tag, " tx_start width"}, tx_start, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                               input int gap, input logic [7:0] ea, input logic [7:0] eb,
                               input logic [5:0] eop, input logic [7:0] etx, input string tag);
    send_byte(a);
    checkOutput({tag, " done low"}, done, 0);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(opb);
    complete_frame(ea, eb, eop, etx, tag);
  endtask

  task automatic finish_frame(input int wait_cycles, input logic [7:0] etx, input string tag);
    idle(wait_cycles);
    checkOutput({tag, " tx_data held"}, tx_data, etx);
    checkOutput({tag, " done before tx_done"}, done, 0);
    tx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    tx_done_tick = 1'b0;
    checkOutput({tag, " done"}, done, 1);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ops[8];
    int         first;
    int         highs;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h05, 8'h03, 6'h20, 8'h08};
    vecs[1] = '{8'h09, 8'h04, 8'hE2, 8'h09, 8'h04, 6'h22, 8'h05};
    vecs[2] = '{8'hF0, 8'h3C, 8'h24, 8'hF0, 8'h3C, 6'h24, 8'h30};
    vecs[3] = '{8'h0F, 8'hF0, 8'h25, 8'h0F, 8'hF0, 6'h25, 8'hFF};
    vecs[4] = '{8'h80, 8'h02, 8'h03, 8'h80, 8'h02, 6'h03, 8'hE0};
    vecs[5] = '{8'h55, 8'hFF, 8'hA6, 8'h55, 8'hFF, 6'h26, 8'hAA};
    vecs[6] = '{8'h33, 8'h44, 8'h67, 8'h33, 8'h44, 6'h27, 8'h88};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = '0;
    tx_done_tick = 1'b0;
    #23;
    check_all_zero("reset");
    reset = 1'b0;
    idle(2);
    check_all_zero("post-reset");

    // tx_done while idle must not produce done
    tx_done_tick = 1'b1;
    idle(1);
    tx_done_tick = 1'b0;
    checkOutput("stray tx_done", done, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op_byte, i % 3, vecs[i].exp_a, vecs[i].exp_b,
                    vecs[i].exp_op, vecs[i].exp_tx, $sformatf("vec%0d", i));
      finish_frame(i % 4, vecs[i].exp_tx, $sformatf("vec%0d", i));
    end
    idle(1);
    checkOutput("done width", done, 0);

    $display("[TB] randomized frames");
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] ropb;
      logic [5:0] rop;
      logic [1:0] hi;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rop  = ops[$urandom_range(0, 7)][5:0];
      hi   = 2'($urandom_range(0, 3));
      ropb = {hi, rop};
      applyStimulus(ra, rb, ropb, $urandom_range(0, 12), ra, rb, rop, alu_model(ra, rb, rop),
                    $sformatf("rnd%0d", i));
      finish_frame($urandom_range(0, 6), alu_model(ra, rb, rop), $sformatf("rnd%0d", i));
    end
    idle(1);

    $display("[TB] timeout");
    send_byte(8'h11);
    first = -1;
    highs = 0;
    for (int i = 1; i <= TO + 3; i++) begin
      @(posedge clk);
      #1;
      if (frame_err) begin
        highs++;
        if (first < 0) first = i;
      end
    end
    checkOutput("timeout latency", first, TO);
    checkOutput("frame_err width", highs, 1);
    checkOutput("timeout alu_a kept", alu_a, 8'h11);
    applyStimulus(8'h01, 8'h02, 8'h20, 0, 8'h01, 8'h02, 6'h20, 8'h03, "post-timeout");
    finish_frame(2, 8'h03, "post-timeout");
    idle(1);

    $display("[TB] byte racing the expiry");
    send_byte(8'h21);
    idle(TO - 1);
    send_byte(8'h42);
    checkOutput("race frame_err", frame_err, 0);
    checkOutput("race alu_b", alu_b, 8'h42);
    idle(3);
    checkOutput("race frame_err later", frame_err, 0);
    send_byte(8'h20);
    complete_frame(8'h21, 8'h42, 6'h20, 8'h63, "race");
    finish_frame(1, 8'h63, "race");
    idle(1);

    $display("[TB] overrun");
    checkOutput("overrun clear", overrun, 0);
    applyStimulus(8'h10, 8'h07, 8'h22, 1, 8'h10, 8'h07, 6'h22, 8'h09, "ovr");
    idle(1);
    send_byte(8'hAA);
    checkOutput("overrun set", overrun, 1);
    checkOutput("overrun alu_a", alu_a, 8'h10);
    finish_frame(1, 8'h09, "ovr");
    idle(3);
    checkOutput("overrun sticky", overrun, 1);

    $display("[TB] reset during WAIT_TX");
    applyStimulus(8'h06, 8'h07, 8'h24, 0, 8'h06, 8'h07, 6'h24, 8'h06, "rst-mid");
    @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    #2;
    reset = 1'b0;
    idle(1);
    applyStimulus(8'hC8, 8'h64, 8'h20, 1, 8'hC8, 8'h64, 6'h20, 8'h2C, "after-reset");
    finish_frame(0, 8'h2C, "after-reset");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
